// File: rtl/lcd_pkg.sv
// Shared LCD definitions: command bytes, ASCII codes and nibble-to-hex helper.
// Used by the sum formatter and by the 4-bit nibble writer.
package lcd_pkg;

    localparam logic [7:0] LCD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_LINE2 = 8'hC0;
    localparam logic [7:0] LCD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_HOME  = 8'h02;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_0  = 8'h30;

    localparam logic [3:0] LAST_ITEM = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SEND
    } fmt_state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cout;
        logic [3:0] sum;
    } operands_t;

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

endpackage

// File: rtl/lcd_sum_formatter.sv
// Formats snapshotted adder operands/result into a 13-item LCD frame
// and streams the items over a valid/ready byte interface.
module lcd_sum_formatter
    import lcd_pkg::*;
#(
    parameter int unsigned REFRESH_CYCLES = 2_500_000,
    parameter logic [7:0]  LINE1_ADDR     = LCD_LINE1,
    parameter logic [7:0]  LINE2_ADDR     = LCD_LINE2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic       out_valid,
    output logic       out_rs,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    fmt_state_t      state;
    logic [3:0]      idx;
    operands_t       snap;
    operands_t       live;
    logic [CW-1:0]   refresh_cnt;
    logic            pending;
    logic            refresh_hit;
    logic            start;
    logic            accept;

    // Returns {rs, data} for one frame position.
    function automatic logic [8:0] item(input logic [3:0] i,
                                        input operands_t s);
        logic [8:0] r;
        r = 9'd0;
        case (i)
            4'd0:  r = {1'b0, LINE1_ADDR};
            4'd1:  r = {1'b1, ASCII_A};
            4'd2:  r = {1'b1, ASCII_EQ};
            4'd3:  r = {1'b1, hex2ascii(s.a)};
            4'd4:  r = {1'b1, ASCII_SP};
            4'd5:  r = {1'b1, ASCII_B};
            4'd6:  r = {1'b1, ASCII_EQ};
            4'd7:  r = {1'b1, hex2ascii(s.b)};
            4'd8:  r = {1'b0, LINE2_ADDR};
            4'd9:  r = {1'b1, ASCII_S};
            4'd10: r = {1'b1, ASCII_EQ};
            4'd11: r = {1'b1, ASCII_0 + {7'd0, s.cout}};
            4'd12: r = {1'b1, hex2ascii(s.sum)};
            default: r = 9'd0;
        endcase
        return r;
    endfunction

    assign live = {a, b, cout, sum};

    assign refresh_hit = (REFRESH_CYCLES != 0) &&
                         (refresh_cnt == CW'(REFRESH_CYCLES - 1));

    assign start  = (state == ST_IDLE) &&
                    (pending || (live != snap) || refresh_hit);

    assign accept = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 4'd0;
            snap        <= '0;
            refresh_cnt <= '0;
            pending     <= 1'b1;
            out_valid   <= 1'b0;
            out_rs      <= 1'b0;
            out_data    <= 8'd0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap               <= live;
                        idx                <= 4'd0;
                        pending            <= 1'b0;
                        refresh_cnt        <= '0;
                        {out_rs, out_data} <= item(4'd0, live);
                        out_valid          <= 1'b1;
                        busy               <= 1'b1;
                        state              <= ST_SEND;
                    end else begin
                        refresh_cnt <= refresh_cnt + CW'(1);
                    end
                end
                ST_SEND: begin
                    // Changes during a frame are deferred to the next one.
                    if (live != snap)
                        pending <= 1'b1;
                    if (accept) begin
                        if (idx == LAST_ITEM) begin
                            state      <= ST_IDLE;
                            out_valid  <= 1'b0;
                            out_rs     <= 1'b0;
                            out_data   <= 8'd0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            idx                <= idx + 4'd1;
                            {out_rs, out_data} <= item(idx + 4'd1, snap);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
